sd_cmd_tx: RTL and testbench

- Downstream consumer of the SD clock divider output.
- Serialises one 48-bit SD command frame onto the CMD line, advancing one bit per falling edge of the divided SD clock.
- Builds the frame (start, transmission bit, index, argument, CRC7, end bit) and computes CRC7 serially while shifting.
- Sits between the host command sequencer and the CMD pad driver; runs entirely in the system clk domain and treats sd_clk as a sampled level.

---
 rtl/sd_cmd_tx.sv | 180 ++++++++++++++++++
 tb/tb_sd_cmd_tx.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_tx.sv
// SD command-line serialiser: shifts one 48-bit command frame (start, dir, index, argument, CRC7, end)
// onto CMD, advancing one bit per falling edge of the divided SD clock sampled in the clk domain.
module sd_cmd_tx #(
    parameter int PRE_IDLE_EDGES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sd_clk,
    input  logic        start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] argument,
    output logic        cmd_out,
    output logic        cmd_oe,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_DATA = 3'd2,
        S_CRC  = 3'd3,
        S_END  = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    localparam logic [7:0] LP_PRE_LAST  = 8'(PRE_IDLE_EDGES > 0 ? PRE_IDLE_EDGES - 1 : 0);
    localparam logic [5:0] LP_DATA_LAST = 6'd39;
    localparam logic [5:0] LP_CRC_LAST  = 6'd6;

    state_t      r_state, w_state_nxt;
    logic [39:0] r_shift, w_shift_nxt;
    logic [6:0]  r_crc, w_crc_nxt;
    logic [5:0]  r_bit_cnt, w_bit_cnt_nxt;
    logic [7:0]  r_pre_cnt, w_pre_cnt_nxt;
    logic        r_cmd_out, w_cmd_out_nxt;
    logic        r_cmd_oe, w_cmd_oe_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_done, w_done_nxt;
    logic        r_sd_clk_q;
    logic        w_fall;

    // One serial CRC7 step, generator x^7 + x^3 + 1.
    function automatic logic [6:0] f_crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    assign w_fall = r_sd_clk_q & ~sd_clk;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_crc      <= '0;
            r_bit_cnt  <= '0;
            r_pre_cnt  <= '0;
            r_cmd_out  <= 1'b1;
            r_cmd_oe   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_sd_clk_q <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_crc      <= w_crc_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_pre_cnt  <= w_pre_cnt_nxt;
            r_cmd_out  <= w_cmd_out_nxt;
            r_cmd_oe   <= w_cmd_oe_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_sd_clk_q <= sd_clk;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_crc_nxt     = r_crc;
        w_bit_cnt_nxt = r_bit_cnt;
        w_pre_cnt_nxt = r_pre_cnt;
        w_cmd_out_nxt = r_cmd_out;
        w_cmd_oe_nxt  = r_cmd_oe;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                w_cmd_out_nxt = 1'b1;
                w_cmd_oe_nxt  = 1'b0;
                w_busy_nxt    = 1'b0;
                // Start is taken regardless of fall; the first bit waits for the next fall.
                if (start) begin
                    w_shift_nxt   = {1'b0, 1'b1, cmd_index, argument};
                    w_crc_nxt     = '0;
                    w_bit_cnt_nxt = '0;
                    w_pre_cnt_nxt = '0;
                    w_busy_nxt    = 1'b1;
                    w_state_nxt   = (PRE_IDLE_EDGES > 0) ? S_PRE : S_DATA;
                end
            end

            S_PRE: begin
                if (w_fall) begin
                    w_cmd_out_nxt = 1'b1;
                    w_cmd_oe_nxt  = 1'b1;
                    if (r_pre_cnt == LP_PRE_LAST) begin
                        w_pre_cnt_nxt = '0;
                        w_state_nxt   = S_DATA;
                    end else begin
                        w_pre_cnt_nxt = r_pre_cnt + 8'd1;
                    end
                end
            end

            S_DATA: begin
                if (w_fall) begin
                    w_cmd_out_nxt = r_shift[39];
                    w_cmd_oe_nxt  = 1'b1;
                    w_crc_nxt     = f_crc7_step(r_crc, r_shift[39]);
                    w_shift_nxt   = {r_shift[38:0], 1'b0};
                    if (r_bit_cnt == LP_DATA_LAST) begin
                        w_bit_cnt_nxt = '0;
                        w_state_nxt   = S_CRC;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 6'd1;
                    end
                end
            end

            S_CRC: begin
                if (w_fall) begin
                    w_cmd_out_nxt = r_crc[6];
                    w_cmd_oe_nxt  = 1'b1;
                    w_crc_nxt     = {r_crc[5:0], 1'b0};
                    if (r_bit_cnt == LP_CRC_LAST) begin
                        w_bit_cnt_nxt = '0;
                        w_state_nxt   = S_END;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 6'd1;
                    end
                end
            end

            S_END: begin
                if (w_fall) begin
                    w_cmd_out_nxt = 1'b1;
                    w_cmd_oe_nxt  = 1'b1;
                    w_state_nxt   = S_FIN;
                end
            end

            S_FIN: begin
                // Release the pad a full bit after the end bit so the card samples it cleanly.
                if (w_fall) begin
                    w_cmd_out_nxt = 1'b1;
                    w_cmd_oe_nxt  = 1'b0;
                    w_busy_nxt    = 1'b0;
                    w_done_nxt    = 1'b1;
                    w_state_nxt   = S_IDLE;
                end
            end

            default: begin
                w_state_nxt   = S_IDLE;
                w_cmd_out_nxt = 1'b1;
                w_cmd_oe_nxt  = 1'b0;
                w_busy_nxt    = 1'b0;
            end
        endcase
    end

    assign cmd_out = r_cmd_out;
    assign cmd_oe  = r_cmd_oe;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_sd_cmd_tx.sv
// Bench for sd_cmd_tx: drives a divided SD clock, captures CMD at sd_clk rising edges and
// compares each frame with a polynomial-division CRC7 model.
module tb_sd_cmd_tx;

    localparam int PRE8 = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        sd_clk;
    logic        start0, start8;
    logic [5:0]  cmd_index;
    logic [31:0] argument;
    logic        out0, oe0, busy0, done0;
    logic        out8, oe8, busy8, done8;

    int n_vec = 0;
    int n_bad = 0;
    int ph = 0;
    int falls = 0;
    bit hold = 0;
    bit cur_sel = 0;
    int dcount = 0;
    int stray = 0;
    int frames_done = 0;
    bit bits[$];

    always #5 clk = ~clk;

    sd_cmd_tx #(.PRE_IDLE_EDGES(0)) u_dut0 (
        .clk(clk), .reset(reset), .sd_clk(sd_clk), .start(start0),
        .cmd_index(cmd_index), .argument(argument),
        .cmd_out(out0), .cmd_oe(oe0), .busy(busy0), .done(done0)
    );

    sd_cmd_tx #(.PRE_IDLE_EDGES(PRE8)) u_dut8 (
        .clk(clk), .reset(reset), .sd_clk(sd_clk), .start(start8),
        .cmd_index(cmd_index), .argument(argument),
        .cmd_out(out8), .cmd_oe(oe8), .busy(busy8), .done(done8)
    );

    function automatic logic s_out();  return cur_sel ? out8  : out0;  endfunction
    function automatic logic s_oe();   return cur_sel ? oe8   : oe0;   endfunction
    function automatic logic s_busy(); return cur_sel ? busy8 : busy0; endfunction
    function automatic logic s_done(); return cur_sel ? done8 : done0; endfunction

    // Frame = {0, 1, index, argument, remainder of M(x)*x^7 / (x^7+x^3+1), 1}.
    function automatic logic [47:0] model_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] m;
        logic [46:0] r;
        m = {2'b01, idx, arg};
        r = {m, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (r[i]) r = r ^ (47'h89 << (i - 7));
        return {m, r[6:0], 1'b1};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clk of sd_clk generation (period = 4 clk); rising edges capture CMD while driven.
    task automatic tick();
        if (!hold) begin
            if (ph == 0) begin
                sd_clk = 1'b0;
                falls++;
            end else if (ph == 2) begin
                if (s_oe()) bits.push_back(s_out());
                sd_clk = 1'b1;
            end
            ph = (ph + 1) % 4;
        end
        @(negedge clk);
        if (s_done()) dcount++;
        if (cur_sel ? done0 : done8) stray++;
    endtask

    task automatic run_frame(input bit sel, input logic [5:0] idx, input logic [31:0] arg,
                             input bit repulse, input bit freeze, input bit rst_mid,
                             input bit use_const, input logic [47:0] const_frame);
        logic [47:0] exp_f, got;
        bit got_done, did_rep, did_frz;
        int busy_bad, hold_bad, pre, ones;
        logic ho, hoe;
        pre      = sel ? PRE8 : 0;
        cur_sel  = sel;
        exp_f    = model_frame(idx, arg);
        got_done = 0; did_rep = 0; did_frz = 0; busy_bad = 0;
        cmd_index = idx;
        argument  = arg;
        if (sel) start8 = 1'b1; else start0 = 1'b1;
        tick();
        start0 = 1'b0; start8 = 1'b0;
        cmd_index = 6'($urandom);
        argument  = $urandom;
        falls = 0;
        bits.delete();
        chk("busy_after_start", 64'(s_busy()), 64'd1);
        for (int cyc = 0; cyc < 4 * (pre + 60) + 300 && !got_done; cyc++) begin
            if (repulse && !did_rep && falls == pre + 10) begin
                did_rep = 1;
                cmd_index = ~idx;
                argument  = ~arg;
                if (sel) start8 = 1'b1; else start0 = 1'b1;
            end
            if (freeze && !did_frz && falls == pre + 20 && ph == 3) begin
                did_frz = 1;
                hold = 1;
                ho = s_out(); hoe = s_oe(); hold_bad = 0;
                repeat (100) begin
                    tick();
                    if (s_out() !== ho || s_oe() !== hoe || s_busy() !== 1'b1) hold_bad++;
                end
                hold = 0;
                chk("freeze_hold", 64'(hold_bad), 64'd0);
            end
            tick();
            start0 = 1'b0; start8 = 1'b0;
            if (rst_mid && falls == pre + 43) begin
                #2 reset = 1'b0;
                #1;
                chk("rst_cmd_out", 64'(s_out()), 64'd1);
                chk("rst_cmd_oe", 64'(s_oe()), 64'd0);
                chk("rst_busy", 64'(s_busy()), 64'd0);
                @(negedge clk);
                reset = 1'b1;
                return;
            end
            if (s_done()) begin
                got_done = 1;
                frames_done++;
                chk("falls_to_done", 64'(falls), 64'(pre + 49));
                chk("busy_at_done", 64'(s_busy()), 64'd0);
                chk("oe_at_done", 64'(s_oe()), 64'd0);
                chk("out_at_done", 64'(s_out()), 64'd1);
            end else if (s_busy() !== 1'b1) begin
                busy_bad++;
            end
        end
        chk("done_seen", 64'(got_done), 64'd1);
        chk("busy_held", 64'(busy_bad), 64'd0);
        chk("bit_count", 64'(bits.size()), 64'(pre + 48));
        ones = 0;
        got  = '0;
        for (int i = 0; i < pre && i < bits.size(); i++) ones += int'(bits[i]);
        for (int i = pre; i < pre + 48 && i < bits.size(); i++) got = {got[46:0], bits[i]};
        if (pre > 0) chk("pre_ones", 64'(ones), 64'(pre));
        chk("frame", 64'(got), 64'(exp_f));
        if (use_const) chk("frame_const", 64'(got), 64'(const_frame));
    endtask

    initial begin
        reset = 1'b0;
        sd_clk = 1'b1;
        start0 = 1'b0; start8 = 1'b0;
        cmd_index = '0; argument = '0;
        repeat (3) @(negedge clk);
        chk("reset_out0", 64'(out0), 64'd1);
        chk("reset_oe0", 64'(oe0), 64'd0);
        chk("reset_busy0", 64'(busy0), 64'd0);
        chk("reset_done0", 64'(done0), 64'd0);
        chk("reset_out8", 64'(out8), 64'd1);
        chk("reset_oe8", 64'(oe8), 64'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        run_frame(0, 6'd0,  32'h0000_0000, 0, 0, 0, 1, 48'h400000000095);
        // Issued the cycle after the previous done, with a spurious start during DATA.
        run_frame(0, 6'd8,  32'h0000_01AA, 1, 0, 0, 1, 48'h48000001AA87);
        run_frame(1, 6'd17, 32'h0000_0000, 0, 0, 0, 1, 48'h510000000055);
        run_frame(0, 6'($urandom), $urandom, 0, 1, 0, 0, '0);
        run_frame(1, 6'($urandom), $urandom, 0, 0, 1, 0, '0);
        run_frame(1, 6'($urandom), $urandom, 0, 0, 0, 0, '0);
        for (int k = 0; k < 4; k++)
            run_frame(bit'(k % 2), 6'($urandom), $urandom, bit'($urandom_range(0, 1)), 0, 0, 0, '0);

        repeat (6) tick();
        chk("done_pulses", 64'(dcount), 64'(frames_done));
        chk("stray_done", 64'(stray), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
